// File: rtl/gcm_pkg.sv
// Shared GF(2^128) definitions in GCM bit order (bit 127 = x^0, bit 0 = x^127).
package gcm_pkg;

    localparam int unsigned GF128_W = 128;

    typedef logic [GF128_W-1:0] gf128_t;

    // x^7 + x^2 + x + 1 folded back in when x^127 overflows
    localparam gf128_t GF128_R = 128'hE1000000_00000000_00000000_00000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } mul_state_t;

    function automatic gf128_t gf128_mulx(input gf128_t v);
        return (v >> 1) ^ (v[0] ? GF128_R : '0);
    endfunction

endpackage

// File: rtl/gf128_mul_digit.sv
// One Horner step of the digit-serial multiplier: z_next = z*x^DIGIT_W mod P xor digit*H.
module gf128_mul_digit
    import gcm_pkg::*;
#(
    parameter int unsigned DIGIT_W = 8
) (
    input  logic [GF128_W-1:0] z,
    input  logic [GF128_W-1:0] h,
    input  logic [DIGIT_W-1:0] digit,
    output logic [GF128_W-1:0] z_next
);

    gf128_t       z_sh;
    gf128_t       h_k;
    gf128_t       pp;
    logic [DIGIT_W-1:0] d;

    // Digit MSB carries the lowest power (x^0) of this digit in GCM order
    always_comb begin
        z_sh = z;
        for (int unsigned i = 0; i < DIGIT_W; i++) begin
            z_sh = gf128_mulx(z_sh);
        end
        h_k = h;
        pp  = '0;
        d   = digit;
        for (int unsigned k = 0; k < DIGIT_W; k++) begin
            if (d[DIGIT_W-1]) begin
                pp = pp ^ h_k;
            end
            h_k = gf128_mulx(h_k);
            d   = d << 1;
        end
        z_next = z_sh ^ pp;
    end

endmodule

// File: rtl/gf128_mul_seq.sv
// Digit-serial GF(2^128) multiplier, Z = X*H mod P, valid/ready on both sides.
// Define GF128_MUL_ACC_EN for GHASH accumulate mode (X_eff = X xor previous Z).
module gf128_mul_seq
    import gcm_pkg::*;
#(
    parameter int unsigned DIGIT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [GF128_W-1:0] in_x,
    input  logic [GF128_W-1:0] in_h,
    input  logic               in_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GF128_W-1:0] out_z
);

    localparam int unsigned N     = GF128_W / DIGIT_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (DIGIT_W != 1 && DIGIT_W != 2 && DIGIT_W != 4 &&
        DIGIT_W != 8 && DIGIT_W != 16 && DIGIT_W != 32) begin : g_bad_digit_w
        $error("gf128_mul_seq: DIGIT_W must be 1, 2, 4, 8, 16 or 32");
    end

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    gf128_t           x_q, x_d;
    gf128_t           h_q, h_d;
    gf128_t           z_q, z_d;
    gf128_t           out_z_q, out_z_d;
    gf128_t           z_step;
    gf128_t           x_eff;
    logic             accept;
    logic             finish;

`ifdef GF128_MUL_ACC_EN
    gf128_t           acc_q, acc_d;
    assign x_eff = in_x ^ (in_clr ? '0 : acc_q);
`else
    logic             clr_unused;
    assign x_eff      = in_x;
    assign clr_unused = in_clr;
`endif

    gf128_mul_digit #(
        .DIGIT_W(DIGIT_W)
    ) u_step (
        .z     (z_q),
        .h     (h_q),
        .digit (x_q[DIGIT_W-1:0]),
        .z_next(z_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid && in_ready) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_LAST)    state_d = ST_DONE;
            ST_DONE: if (out_ready)            state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    assign accept = in_valid && (state_q == ST_IDLE);
    assign finish = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    assign out_z  = out_z_q;

    // X is shifted down one digit per step so the active digit is always x_q[DIGIT_W-1:0]
    always_comb begin
        x_d     = x_q;
        h_d     = h_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        out_z_d = out_z_q;
`ifdef GF128_MUL_ACC_EN
        acc_d   = acc_q;
`endif
        if (accept) begin
            x_d   = x_eff;
            h_d   = in_h;
            z_d   = '0;
            cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            x_d   = x_q >> DIGIT_W;
            z_d   = z_step;
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (finish) begin
            out_z_d = z_step;
`ifdef GF128_MUL_ACC_EN
            acc_d   = z_step;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            h_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            out_z_q <= '0;
`ifdef GF128_MUL_ACC_EN
            acc_q   <= '0;
`endif
        end else begin
            x_q     <= x_d;
            h_q     <= h_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            out_z_q <= out_z_d;
`ifdef GF128_MUL_ACC_EN
            acc_q   <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_gf128_mul_seq.sv
// Directed-vector bench for gf128_mul_seq (DIGIT_W=8 main instance plus one per other width).
// Accumulate-mode vectors are exercised when GF128_MUL_ACC_EN is defined.
module tb_gf128_mul_seq;

    localparam int N = 16;
    localparam logic [127:0] H     = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] ONE   = 128'h80000000_00000000_00000000_00000000;
    localparam logic [127:0] X127  = 128'h00000000_00000000_00000000_00000001;
    localparam logic [127:0] XPOW1 = 128'h40000000_00000000_00000000_00000000;
    localparam logic [127:0] RED   = 128'hE1000000_00000000_00000000_00000000;
    localparam logic [127:0] GX    = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] GZ    = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] X2    = 128'h00000000000000000000000000000080;
    localparam logic [127:0] ACC2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_x;
    logic [127:0] in_h;
    logic         in_clr;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_z;

    logic         ex_valid;
    logic         ex_ready;
    logic         ex_in_ready[5];
    logic         ex_out_valid[5];
    logic [127:0] ex_z[5];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf128_mul_seq #(
        .DIGIT_W(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_h     (in_h),
        .in_clr   (in_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_z    (out_z)
    );

    for (genvar g = 0; g < 5; g++) begin : g_ex
        gf128_mul_seq #(
            .DIGIT_W((g < 3) ? (1 << g) : (1 << (g + 1)))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (ex_valid),
            .in_ready (ex_in_ready[g]),
            .in_x     (in_x),
            .in_h     (in_h),
            .in_clr   (1'b1),
            .out_valid(ex_out_valid[g]),
            .out_ready(ex_ready),
            .out_z    (ex_z[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [127:0] x, input logic [127:0] h, input logic clr,
                          input string tag, input logic [127:0] exp);
        int lat;
        check({tag, "_rdy"}, 128'(in_ready), 128'(1));
        in_x     = x;
        in_h     = h;
        in_clr   = clr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x     = {4{$urandom}};
        in_h     = {4{$urandom}};
        in_clr   = 1'b0;
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(N));
        check({tag, "_z"}, out_z, exp);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_low"}, 128'(out_valid), 128'(0));
        check({tag, "_idle"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        int pulses;
        int ex_lat[5];
        int ex_w[5];
        ex_w = '{1, 2, 4, 16, 32};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_h      = '0;
        in_clr    = 1'b1;
        out_ready = 1'b0;
        ex_valid  = 1'b0;
        ex_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_z", out_z, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(ONE, H, 1'b1, "ident", H);
        handshake("ident");
        run_op(X127, XPOW1, 1'b1, "reduce", RED);
        handshake("reduce");
        run_op(GX, H, 1'b1, "gcm", GZ);
        handshake("gcm");
        repeat (3) @(posedge clk);
        #1;
        check("hold_out_z", out_z, GZ);

        // Backpressure: result held while a new request waits, then released
        run_op(ONE, XPOW1, 1'b1, "bp", XPOW1);
        in_valid = 1'b1;
        in_x     = GX;
        in_h     = H;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_z", out_z, XPOW1);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_out_valid", 128'(out_valid), 128'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_rel_idle", 128'(in_ready), 128'(1));
        check("bp_rel_ov", 128'(out_valid), 128'(0));
        check("bp_rel_z", out_z, XPOW1);

        // Reset in the middle of RUN
        in_x     = GX;
        in_h     = H;
        in_clr   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 128'(in_ready), 128'(1));
        check("arst_out_valid", 128'(out_valid), 128'(0));
        check("arst_out_z", out_z, '0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("arst_no_pulse", 128'(pulses), 128'(0));
        run_op(GX, H, 1'b0, "post_rst", GZ);
        handshake("post_rst");

`ifdef GF128_MUL_ACC_EN
        run_op(GX, H, 1'b1, "acc1", GZ);
        handshake("acc1");
        run_op(X2, H, 1'b0, "acc2", ACC2);
        handshake("acc2");
`endif

        // Same GCM vector through every other legal digit width
        in_x = GX;
        in_h = H;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("ex%0d_rdy", ex_w[g]), 128'(ex_in_ready[g]), 128'(1));
            ex_lat[g] = 0;
        end
        ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        in_x     = '0;
        in_h     = '0;
        for (int c = 1; c <= 140; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 5; g++) begin
                if (ex_out_valid[g] && ex_lat[g] == 0) ex_lat[g] = c;
            end
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("ex%0d_lat", ex_w[g]), 128'(ex_lat[g]), 128'(128 / ex_w[g]));
            check($sformatf("ex%0d_z", ex_w[g]), ex_z[g], GZ);
        end
        ex_ready = 1'b1;
        @(posedge clk); #1;
        ex_ready = 1'b0;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("ex%0d_ov_low", ex_w[g]), 128'(ex_out_valid[g]), 128'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
